// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and byte payload for the character-LCD path.
package lcd_pkg;

   localparam logic [7:0]  LCD_CMD_LINE1 = 8'h80;
   localparam logic [7:0]  LCD_CMD_LINE2 = 8'hC0;
   localparam int unsigned LCD_COLS      = 16;
   localparam int unsigned LCD_ROWS      = 2;
   localparam int unsigned LCD_CELLS     = LCD_ROWS * LCD_COLS;
   localparam int unsigned COL_W         = 4;
   localparam int unsigned IDX_W         = 5;
   localparam int unsigned CHAR_W        = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR1,
      ST_LINE1,
      ST_ADDR2,
      ST_LINE2
   } lcd_state_e;

   typedef struct packed {
      logic              rs;
      logic [CHAR_W-1:0] data;
   } lcd_byte_t;

   // Flat cell index: row-major, 16 cells per line.
   function automatic logic [IDX_W-1:0] cell_idx(input logic row, input logic [COL_W-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/lcd_frame_source_if.sv
// Valid/ready byte stream from the frame source to the LCD driver.
interface lcd_frame_source_if;
   import lcd_pkg::*;

   logic      valid;
   logic      ready;
   lcd_byte_t payload;

   modport master (output valid, output payload, input ready);
   modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/lcd_char_ram.sv
// 32x8 character register file: one write port, full clear, combinational read.
module lcd_char_ram
   import lcd_pkg::*;
#(
   parameter logic [CHAR_W-1:0] BLANK_CHAR = 8'h20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [CHAR_W-1:0] wr_char,
   input  logic              clr,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [CHAR_W-1:0] rd_char_c
);

   logic [CHAR_W-1:0] mem [LCD_CELLS];

   // Clear first, then the write, so a simultaneous write survives the clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem <= '{default: BLANK_CHAR};
      end else begin
         if (clr) begin
            mem <= '{default: BLANK_CHAR};
         end
         if (wr_en) begin
            mem[wr_idx] <= wr_char;
         end
      end
   end

   assign rd_char_c = mem[rd_idx];

endmodule

// File: rtl/lcd_frame_source.sv
// Frame buffer plus refresh sequencer: streams 0x80, line 1, 0xC0, line 2 whenever dirty.
module lcd_frame_source
   import lcd_pkg::*;
#(
   parameter logic [CHAR_W-1:0] BLANK_CHAR = 8'h20
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic                wr_row,
   input  logic [COL_W-1:0]    wr_col,
   input  logic [CHAR_W-1:0]   wr_char,
   input  logic                clr,
   lcd_frame_source_if.master  stream,
   output logic                frame_done,
   output logic                dirty
);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(LCD_COLS - 1);

   lcd_state_e        state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              valid_q, valid_d;
   lcd_byte_t         byte_q, byte_d;
   logic              done_q, done_d;
   logic              dirty_q, dirty_d;
   logic              beat;
   logic [IDX_W-1:0]  rd_idx;
   logic [CHAR_W-1:0] rd_char_c;

   lcd_char_ram #(.BLANK_CHAR(BLANK_CHAR)) u_ram (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_idx    (cell_idx(wr_row, wr_col)),
      .wr_char   (wr_char),
      .clr       (clr),
      .rd_idx    (rd_idx),
      .rd_char_c (rd_char_c)
   );

   // Address of the character that would be loaded if the current beat completes.
   always_comb begin
      rd_idx = '0;
      case (state_q)
         ST_LINE1: rd_idx = cell_idx(1'b0, col_q + COL_W'(1));
         ST_ADDR2: rd_idx = cell_idx(1'b1, '0);
         ST_LINE2: rd_idx = cell_idx(1'b1, col_q + COL_W'(1));
         default:  rd_idx = cell_idx(1'b0, '0);
      endcase
   end

   // Next-state, column, output-register load and dirty tracking.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      valid_d = valid_q;
      byte_d  = byte_q;
      done_d  = 1'b0;
      dirty_d = dirty_q;
      beat    = valid_q & stream.ready;

      case (state_q)
         ST_IDLE: begin
            col_d   = '0;
            valid_d = 1'b0;
            if (dirty_q) begin
               state_d = ST_ADDR1;
               valid_d = 1'b1;
               byte_d  = '{rs: 1'b0, data: LCD_CMD_LINE1};
               dirty_d = 1'b0;
            end
         end
         ST_ADDR1: begin
            if (beat) begin
               state_d = ST_LINE1;
               col_d   = '0;
               byte_d  = '{rs: 1'b1, data: rd_char_c};
            end
         end
         ST_LINE1: begin
            if (beat) begin
               if (col_q == LAST_COL) begin
                  state_d = ST_ADDR2;
                  col_d   = '0;
                  byte_d  = '{rs: 1'b0, data: LCD_CMD_LINE2};
               end else begin
                  col_d  = col_q + COL_W'(1);
                  byte_d = '{rs: 1'b1, data: rd_char_c};
               end
            end
         end
         ST_ADDR2: begin
            if (beat) begin
               state_d = ST_LINE2;
               col_d   = '0;
               byte_d  = '{rs: 1'b1, data: rd_char_c};
            end
         end
         ST_LINE2: begin
            if (beat) begin
               if (col_q == LAST_COL) begin
                  state_d = ST_IDLE;
                  col_d   = '0;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  col_d  = col_q + COL_W'(1);
                  byte_d = '{rs: 1'b1, data: rd_char_c};
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            col_d   = '0;
            valid_d = 1'b0;
         end
      endcase

      // A host update in the frame-start cycle must still schedule another frame.
      if (wr_en || clr) begin
         dirty_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         valid_q <= 1'b0;
         byte_q  <= '0;
         done_q  <= 1'b0;
         dirty_q <= 1'b1;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         valid_q <= valid_d;
         byte_q  <= byte_d;
         done_q  <= done_d;
         dirty_q <= dirty_d;
      end
   end

   assign stream.valid   = valid_q;
   assign stream.payload = byte_q;
   assign frame_done     = done_q;
   assign dirty          = dirty_q;

endmodule

// File: tb/tb_lcd_frame_source.sv
// Randomized bench for lcd_frame_source against a frame-level buffer model.
module tb_lcd_frame_source;
   import lcd_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic       wr_row = 1'b0;
   logic [3:0] wr_col = 4'd0;
   logic [7:0] wr_char = 8'd0;
   logic       clr = 1'b0;
   logic       frame_done;
   logic       dirty;

   lcd_frame_source_if bus ();

   lcd_frame_source dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_row     (wr_row),
      .wr_col     (wr_col),
      .wr_char    (wr_char),
      .clr        (clr),
      .stream     (bus),
      .frame_done (frame_done),
      .dirty      (dirty)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] mbuf [32];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
   endtask

   // Beat k (0-based) of a refresh built from the model buffer.
   function automatic logic [8:0] exp_beat(input int k);
      if (k == 0)       return {1'b0, 8'h80};
      else if (k <= 16) return {1'b1, mbuf[k-1]};
      else if (k == 17) return {1'b0, 8'hC0};
      else              return {1'b1, mbuf[k-2]};
   endfunction

   function automatic logic [8:0] presented();
      return {bus.payload.rs, bus.payload.data};
   endfunction

   task automatic host_op(input bit do_clr, input bit do_wr, input logic row,
                          input logic [3:0] col, input logic [7:0] ch);
      @(posedge clk); #1;
      clr     = do_clr;
      wr_en   = do_wr;
      wr_row  = row;
      wr_col  = col;
      wr_char = ch;
      if (do_clr) for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
      if (do_wr) mbuf[int'(row) * 16 + int'(col)] = ch;
   endtask

   task automatic idle_check(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         wr_en = 1'b0;
         clr   = 1'b0;
         @(negedge clk);
         check_eq("idle_valid", 32'(bus.valid), 32'd0);
      end
      check_eq("idle_dirty", 32'(dirty), 32'd0);
   endtask

   // Collect one frame, comparing every beat with the snapshot taken at frame start.
   task automatic run_frame(input int stall_at, input int stall_len, input bit rnd,
                            input int inj_at, input int abort_at, input bit more);
      logic [8:0] exp [34];
      logic [8:0] held;
      bit         hold_chk = 0;
      bit         injected = 0;
      int         n = 0, cyc = 0, stall = 0, first = -1, last = 0;
      for (int k = 0; k < 34; k++) exp[k] = exp_beat(k);
      while (n < 34 && cyc < 600) begin
         @(posedge clk); #1;
         wr_en = 1'b0;
         clr   = 1'b0;
         if (abort_at == n + 1 && bus.valid) begin
            reset     = 1'b0;
            bus.ready = 1'b0;
            @(negedge clk);
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("abort_valid", 32'(bus.valid), 32'd0);
            check_eq("abort_done", 32'(frame_done), 32'd0);
            return;
         end
         if (stall_at == n + 1 && stall < stall_len && bus.valid) begin
            bus.ready = 1'b0;
            stall++;
         end else begin
            bus.ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (inj_at == n + 1 && !injected) begin
            injected = 1;
            wr_en = 1'b1; wr_row = 1'b0; wr_col = 4'd0; wr_char = 8'h41;
            mbuf[0] = 8'h41;
         end
         @(negedge clk);
         cyc++;
         if (bus.valid && hold_chk) check_eq("stall_hold", 32'(presented()), 32'(held));
         hold_chk = 0;
         if (bus.valid && bus.ready) begin
            check_eq($sformatf("beat%0d", n + 1), 32'(presented()), 32'(exp[n]));
            if (first < 0) first = cyc;
            last = cyc;
            n++;
         end else if (bus.valid) begin
            held     = presented();
            hold_chk = 1;
         end
      end
      check_eq("beat_count", 32'(n), 32'd34);
      if (!rnd && stall_len == 0) check_eq("contiguous", 32'(last - first + 1), 32'd34);
      @(posedge clk); #1;
      bus.ready = 1'b0;
      wr_en = 1'b0;
      clr   = 1'b0;
      @(negedge clk);
      check_eq("done_pulse", 32'(frame_done), 32'd1);
      check_eq("done_valid", 32'(bus.valid), 32'd0);
      check_eq("done_dirty", 32'(dirty), 32'(more));
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("gap_valid", 32'(bus.valid), 32'(more));
      check_eq("done_once", 32'(frame_done), 32'd0);
   endtask

   initial begin
      int nops;
      bus.ready = 1'b0;
      model_reset();

      // Reset values, then the blank frame that follows reset.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_valid", 32'(bus.valid), 32'd0);
      check_eq("rst_payload", 32'(presented()), 32'd0);
      check_eq("rst_done", 32'(frame_done), 32'd0);
      check_eq("rst_dirty", 32'(dirty), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      run_frame(0, 0, 0, 0, 0, 0);
      idle_check(5);

      // Two idle writes; the second lands in the frame-start cycle, so a repeat frame follows.
      host_op(0, 1, 1'b0, 4'd0, 8'h4B);
      host_op(0, 1, 1'b1, 4'd15, 8'h25);
      run_frame(0, 0, 0, 0, 0, 1);
      run_frame(0, 0, 0, 0, 0, 0);
      idle_check(4);

      // Five-cycle stall on beat 10.
      host_op(0, 1, 1'b1, 4'd4, 8'h2A);
      run_frame(10, 5, 0, 0, 0, 0);

      // Write to an already-sent cell during line 2.
      host_op(0, 1, 1'b1, 4'd1, 8'h33);
      run_frame(0, 0, 0, 22, 0, 1);
      run_frame(0, 0, 0, 0, 0, 0);

      // Clear and write in the same cycle.
      host_op(1, 1, 1'b0, 4'd3, 8'h69);
      run_frame(0, 0, 0, 0, 0, 0);
      check_eq("clr_cell", 32'(mbuf[3]), 32'h69);

      // Reset mid-frame, then a fresh blank frame.
      host_op(0, 1, 1'b0, 4'd7, 8'h55);
      run_frame(0, 0, 0, 0, 25, 0);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      run_frame(0, 0, 0, 0, 0, 0);

      // Random bursts of host updates with random backpressure.
      for (int it = 0; it < 8; it++) begin
         nops = $urandom_range(1, 3);
         for (int j = 0; j < nops; j++) begin
            host_op($urandom_range(0, 5) == 0, 1, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 8'($urandom_range(32, 126)));
         end
         run_frame(0, 0, 1, 0, 0, nops > 1);
         if (nops > 1) run_frame(0, 0, 1, 0, 0, 0);
      end
      idle_check(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
